// File: rtl/huffman_pkg.sv
// ---------------------------------------------------------------------------
// huffman_pkg
// Shared types and constants for the Huffman encoder stage sequencer.
//   seq_state_t    : sequencer state encoding (IDLE, LAUNCH, WAIT, DONE)
//   STG_*          : stage indices of the encoder datapath in run order
//   DEF_NUM_STAGES : default number of sequenced stages
// ---------------------------------------------------------------------------
package huffman_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   localparam int STG_GETNUM     = 0;
   localparam int STG_TREE       = 1;
   localparam int STG_CODE       = 2;
   localparam int STG_OUT        = 3;

   localparam int DEF_NUM_STAGES = 4;

endpackage

// File: rtl/huffman_next_stage.sv
// ---------------------------------------------------------------------------
// huffman_next_stage
// Combinational search for the next stage to run.
//   i_mask  : skip mask, bit i=1 means stage i is bypassed
//   i_cur   : index of the current stage
//   i_first : 1 = search from index 0 (first stage of a run),
//             0 = search strictly above i_cur
//   o_next  : lowest unskipped index found (0 when none)
//   o_none  : 1 when no unskipped index qualifies
// ---------------------------------------------------------------------------
module huffman_next_stage
   import huffman_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic [NUM_STAGES-1:0] i_mask,
   input  logic [STG_W-1:0]      i_cur,
   input  logic                  i_first,
   output logic [STG_W-1:0]      o_next,
   output logic                  o_none
);

   // Descending scan: the last qualifying hit is the lowest index.
   always_comb begin
      o_next = '0;
      o_none = 1'b1;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (!i_mask[i] && (i_first || (i > int'(i_cur)))) begin
            o_next = STG_W'(i);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/huffman_stage_seq.sv
// ---------------------------------------------------------------------------
// huffman_stage_seq
// Generic N-stage start/finish sequencer for the Huffman encoder datapath.
// Strobes each unskipped stage in index order, waits for its finish flag,
// and reports completion, per-stage timeout, abort and continuous re-run.
//
// Ports
//   Clk_in      : clock, rising edge
//   Rst         : asynchronous active-high reset
//   Start       : level; a rising edge seen in IDLE launches a run
//   Abort       : ends an active run, blocks a launch in IDLE
//   Cont        : re-run automatically after Done
//   Skip_mask   : per-stage bypass, captured at launch
//   Timeout_lim : max WAIT cycles per stage (0 = no limit), captured at launch
//   Stage_fin   : finish flags from the stages
//   Stage_start : one-hot one-cycle start strobe
//   Busy        : high in LAUNCH, WAIT and DONE
//   Done        : one-cycle pulse on run completion
//   Err         : sticky timeout flag, cleared by the next launch
//   Err_stage   : index of the stage that timed out
//   Cur_stage   : index of the active stage
//   Dbg_state   : current sequencer state
//
// Handshake: Stage_start[i] is a single-cycle pulse; the stage answers with
// Stage_fin[i] (level or pulse), which is only honoured while the sequencer
// is in WAIT for that same stage. Every output is a register.
// ---------------------------------------------------------------------------
module huffman_stage_seq
   import huffman_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int TIMEOUT_W  = 16,
   parameter int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  Clk_in,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic                  Abort,
   input  logic                  Cont,
   input  logic [NUM_STAGES-1:0] Skip_mask,
   input  logic [TIMEOUT_W-1:0]  Timeout_lim,
   input  logic [NUM_STAGES-1:0] Stage_fin,
   output logic [NUM_STAGES-1:0] Stage_start,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err,
   output logic [STG_W-1:0]      Err_stage,
   output logic [STG_W-1:0]      Cur_stage,
   output seq_state_t            Dbg_state
);

   seq_state_t              r_state;
   logic                    r_start_q;
   logic [NUM_STAGES-1:0]   r_mask;
   logic [TIMEOUT_W-1:0]    r_lim;
   logic [TIMEOUT_W-1:0]    r_timer;
   logic [STG_W-1:0]        r_cur;
   logic [NUM_STAGES-1:0]   r_stage_start;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;
   logic [STG_W-1:0]        r_err_stage;

   logic [NUM_STAGES-1:0]   w_first_mask;
   logic [STG_W-1:0]        w_first_idx;
   logic                    w_first_none;
   logic [NUM_STAGES-1:0]   w_first_oh;
   logic [STG_W-1:0]        w_next_idx;
   logic                    w_next_none;
   logic [NUM_STAGES-1:0]   w_next_oh;
   logic                    w_launch;
   logic                    w_timeout;

   // In IDLE the first stage comes from the live mask (it is being captured
   // on the same edge); on a continuous re-run it comes from the held copy.
   assign w_first_mask = (r_state == IDLE) ? Skip_mask : r_mask;

   huffman_next_stage #(
      .NUM_STAGES (NUM_STAGES),
      .STG_W      (STG_W)
   ) u_first (
      .i_mask  (w_first_mask),
      .i_cur   ('0),
      .i_first (1'b1),
      .o_next  (w_first_idx),
      .o_none  (w_first_none)
   );

   huffman_next_stage #(
      .NUM_STAGES (NUM_STAGES),
      .STG_W      (STG_W)
   ) u_next (
      .i_mask  (r_mask),
      .i_cur   (r_cur),
      .i_first (1'b0),
      .o_next  (w_next_idx),
      .o_none  (w_next_none)
   );

   assign w_first_oh = NUM_STAGES'(1) << w_first_idx;
   assign w_next_oh  = NUM_STAGES'(1) << w_next_idx;

   assign w_launch  = Start && !r_start_q && !Abort;
   // Timer reads n-1 in the n-th WAIT cycle, so this fires on cycle T.
   assign w_timeout = (r_lim != '0) && (r_timer == (r_lim - TIMEOUT_W'(1)));

   always_ff @(posedge Clk_in or posedge Rst) begin
      if (Rst) begin
         r_state       <= IDLE;
         r_start_q     <= 1'b0;
         r_mask        <= '0;
         r_lim         <= '0;
         r_timer       <= '0;
         r_cur         <= '0;
         r_stage_start <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_err_stage   <= '0;
      end else begin
         r_start_q     <= Start;
         r_stage_start <= '0;
         r_done        <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_mask <= Skip_mask;
                  r_lim  <= Timeout_lim;
                  r_err  <= 1'b0;
                  r_cur  <= w_first_idx;
                  r_busy <= 1'b1;
                  if (w_first_none) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= LAUNCH;
                     r_stage_start <= w_first_oh;
                  end
               end
            end
            LAUNCH: begin
               if (Abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_timer <= '0;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (Abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (Stage_fin[r_cur]) begin
                  // Finish beats a timeout on the same edge.
                  if (w_next_none) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_cur         <= w_next_idx;
                     r_state       <= LAUNCH;
                     r_stage_start <= w_next_oh;
                  end
               end else if (w_timeout) begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_err       <= 1'b1;
                  r_err_stage <= r_cur;
               end else if (r_timer != {TIMEOUT_W{1'b1}}) begin
                  r_timer <= r_timer + TIMEOUT_W'(1);
               end
            end
            DONE: begin
               if (Abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (Cont) begin
                  r_cur <= w_first_idx;
                  if (w_first_none) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= LAUNCH;
                     r_stage_start <= w_first_oh;
                  end
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Stage_start = r_stage_start;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign Err         = r_err;
   assign Err_stage   = r_err_stage;
   assign Cur_stage   = r_cur;
   assign Dbg_state   = r_state;

endmodule

// File: tb/tb_huffman_stage_seq.sv
// ---------------------------------------------------------------------------
// tb_huffman_stage_seq
// Bench for huffman_stage_seq (NUM_STAGES=4). A stage responder answers each
// strobe with a fin pulse after a configured number of WAIT cycles. Runs are
// checked cycle by cycle against a timeline computed from the stage latencies
// and the limit, plus hand-computed table vectors and corner sequences.
// ---------------------------------------------------------------------------
module tb_huffman_stage_seq;
   import huffman_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        cont = 1'b0;
   logic [3:0]  skip_mask = '0;
   logic [15:0] tlim = '0;
   logic [3:0]  stage_fin;
   logic [3:0]  stage_start;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_stage;
   logic [1:0]  cur_stage;
   seq_state_t  dbg_state;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   huffman_stage_seq dut (
      .Clk_in      (clk),
      .Rst         (rst),
      .Start       (start),
      .Abort       (abort),
      .Cont        (cont),
      .Skip_mask   (skip_mask),
      .Timeout_lim (tlim),
      .Stage_fin   (stage_fin),
      .Stage_start (stage_start),
      .Busy        (busy),
      .Done        (done),
      .Err         (err),
      .Err_stage   (err_stage),
      .Cur_stage   (cur_stage),
      .Dbg_state   (dbg_state)
   );

   // ---------------- stage responder ----------------
   // lat_cfg[i]=n: fin pulse is sampled on the n-th WAIT cycle; 0 = never.
   int         lat_cfg [4];
   int         fin_cnt [4];
   logic [3:0] fin_auto  = '0;
   logic [3:0] fin_force = '0;
   assign stage_fin = fin_auto | fin_force;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         fin_auto[i] = 1'b0;
         if (rst) begin
            fin_cnt[i] = 0;
         end else begin
            if (fin_cnt[i] > 0) begin
               fin_cnt[i] = fin_cnt[i] - 1;
               if (fin_cnt[i] == 0) fin_auto[i] = 1'b1;
            end
            if (stage_start[i]) fin_cnt[i] = lat_cfg[i];
         end
      end
   end

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference timeline ----------------
   // Index r = outputs seen just after the r-th edge counted from the edge
   // that samples the Start rising edge (r=0).
   logic [3:0] m_ss   [64];
   bit         m_busy [64];
   bit         m_done [64];
   bit         m_err  [64];
   int         m_cur  [64];
   int         m_end;
   int         m_err_stage;

   task automatic build_model(input logic [3:0] mask, input logic [15:0] lim,
                              input logic [15:0] lats);
      int t;
      int lat;
      int q[$];
      bit hit_err;
      for (int r = 0; r < 64; r++) begin
         m_ss[r] = '0; m_busy[r] = 0; m_done[r] = 0; m_err[r] = 0; m_cur[r] = 0;
      end
      m_err_stage = 0;
      t = 0;
      hit_err = 0;
      for (int i = 0; i < 4; i++) if (!mask[i]) q.push_back(i);
      if (q.size() == 0) begin
         m_done[0] = 1;
         m_end = 1;
      end else begin
         foreach (q[j]) begin
            if (!hit_err) begin
               m_ss[t][q[j]] = 1'b1;
               for (int r = t; r < 64; r++) m_cur[r] = q[j];
               lat = int'(lats[4*q[j] +: 4]);
               if (lat == 0 || (lim != 0 && lat > int'(lim))) begin
                  hit_err = 1;
                  m_end = t + 1 + int'(lim);
                  m_err_stage = q[j];
                  for (int r = m_end; r < 64; r++) m_err[r] = 1;
               end else begin
                  t = t + 1 + lat;
               end
            end
         end
         if (!hit_err) begin
            m_done[t] = 1;
            m_end = t + 1;
         end
      end
      for (int r = 0; r < m_end; r++) m_busy[r] = 1;
   endtask

   // Launch one run, compare every cycle against the timeline, and return
   // observed aggregates for table checks.
   task automatic run_check(input logic [3:0] mask, input logic [15:0] lim,
                            input logic [15:0] lats, input bit restart_pulse,
                            output int o_n, output logic [7:0] o_order,
                            output int o_done, output bit o_err,
                            output int o_err_stage, output int o_end);
      o_n = 0; o_order = '0; o_done = 0; o_end = -1;
      for (int i = 0; i < 4; i++) lat_cfg[i] = int'(lats[4*i +: 4]);
      build_model(mask, lim, lats);
      @(negedge clk);
      skip_mask = mask;
      tlim = lim;
      start = 1'b1;
      for (int r = 0; r <= m_end + 2; r++) begin
         @(negedge clk);
         if (r == 0) start = 1'b0;
         if (r == 1) begin
            skip_mask = 4'($urandom);
            tlim = 16'($urandom_range(1, 3));
         end
         if (r == 2 && restart_pulse && m_end > 2) start = 1'b1;
         chk($sformatf("strobe r%0d", r), 32'(stage_start), 32'(m_ss[r]));
         chk($sformatf("busy r%0d", r), 32'(busy), 32'(m_busy[r]));
         chk($sformatf("done r%0d", r), 32'(done), 32'(m_done[r]));
         chk($sformatf("err r%0d", r), 32'(err), 32'(m_err[r]));
         chk($sformatf("cur r%0d", r), 32'(cur_stage), 32'(m_cur[r]));
         if (m_err[r]) chk($sformatf("err_stage r%0d", r), 32'(err_stage), 32'(m_err_stage));
         for (int i = 0; i < 4; i++) begin
            if (stage_start[i]) begin
               if (o_n < 4) o_order[2*o_n +: 2] = 2'(i);
               o_n++;
            end
         end
         if (done) o_done++;
         if (!busy && o_end < 0) o_end = r;
         o_err = err;
         o_err_stage = int'(err_stage);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      string       name;
      logic [3:0]  mask;
      logic [15:0] lim;
      logic [15:0] lats;      // nibble i = latency of stage i
      int          n_strobe;
      logic [7:0]  order;     // 2 bits per strobe, first strobe in [1:0]
      int          n_done;
      bit          exp_err;
      int          err_stg;
      int          end_r;     // first r with Busy low
   } vec_t;

   vec_t vecs [6];

   initial begin
      int         n, n_done, e_stage, e_end;
      logic [7:0] order;
      bit         e_err;
      logic [3:0] rmask;
      logic [15:0] rlim, rlats;

      vecs[0] = '{"basic",   4'b0000, 16'd0, 16'h3333, 4, 8'hE4, 1, 0, 0, 17};
      vecs[1] = '{"skip",    4'b0101, 16'd0, 16'h3333, 2, 8'h0D, 1, 0, 0, 9};
      vecs[2] = '{"timeout", 4'b0000, 16'd5, 16'h3033, 3, 8'h24, 0, 1, 2, 14};
      vecs[3] = '{"race",    4'b0000, 16'd4, 16'h2224, 4, 8'hE4, 1, 0, 0, 15};
      vecs[4] = '{"late",    4'b0000, 16'd4, 16'h2225, 1, 8'h00, 0, 1, 0, 5};
      vecs[5] = '{"allskip", 4'b1111, 16'd0, 16'h3333, 0, 8'h00, 1, 0, 0, 1};

      // ---- reset ----
      repeat (3) @(negedge clk);
      chk("rst strobe", 32'(stage_start), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst err", 32'(err), 0);
      chk("rst err_stage", 32'(err_stage), 0);
      chk("rst cur", 32'(cur_stage), 0);
      chk("rst state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ---- table ----
      foreach (vecs[v]) begin
         run_check(vecs[v].mask, vecs[v].lim, vecs[v].lats, 1'b0,
                   n, order, n_done, e_err, e_stage, e_end);
         chk({vecs[v].name, " n_strobe"}, 32'(n), 32'(vecs[v].n_strobe));
         chk({vecs[v].name, " order"}, 32'(order), 32'(vecs[v].order));
         chk({vecs[v].name, " n_done"}, 32'(n_done), 32'(vecs[v].n_done));
         chk({vecs[v].name, " err"}, 32'(e_err), 32'(vecs[v].exp_err));
         if (vecs[v].exp_err) chk({vecs[v].name, " err_stage"}, 32'(e_stage), 32'(vecs[v].err_stg));
         chk({vecs[v].name, " busy_end"}, 32'(e_end), 32'(vecs[v].end_r));
      end

      // ---- randomized runs against the timeline model ----
      for (int k = 0; k < 25; k++) begin
         rmask = 4'($urandom_range(0, 15));
         rlim  = 16'($urandom_range(0, 6));
         for (int i = 0; i < 4; i++)
            rlats[4*i +: 4] = 4'((rlim == 0) ? $urandom_range(1, 6) : $urandom_range(0, 6));
         run_check(rmask, rlim, rlats, 1'($urandom_range(0, 1)),
                   n, order, n_done, e_err, e_stage, e_end);
      end

      // ---- abort in WAIT with the active stage's fin high ----
      lat_cfg[0] = 2; lat_cfg[1] = 0; lat_cfg[2] = 2; lat_cfg[3] = 2;
      @(negedge clk);
      skip_mask = 4'b0000; tlim = 16'd0; start = 1'b1;
      for (int r = 0; r <= 12; r++) begin
         @(negedge clk);
         if (r == 0) start = 1'b0;
         if (r == 3) chk("abort setup strobe1", 32'(stage_start), 32'h2);
         if (r == 5) begin
            chk("abort setup busy", 32'(busy), 1);
            abort = 1'b1;
            fin_force = 4'b0010;
         end
         if (r == 6) begin
            chk("abort busy", 32'(busy), 0);
            chk("abort strobe", 32'(stage_start), 0);
            chk("abort done", 32'(done), 0);
            chk("abort state", 32'(dbg_state), 32'(IDLE));
            abort = 1'b0;
            fin_force = '0;
         end
         if (r > 6) begin
            chk($sformatf("post-abort strobe r%0d", r), 32'(stage_start), 0);
            chk($sformatf("post-abort done r%0d", r), 32'(done), 0);
         end
      end

      // ---- abort in IDLE blocks a simultaneous Start edge ----
      @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("idle abort busy", 32'(busy), 0);
      chk("idle abort strobe", 32'(stage_start), 0);
      abort = 1'b0;
      @(negedge clk);
      chk("idle abort held start busy", 32'(busy), 0);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // ---- continuous mode, mask 1110, stage0 latency 3 ----
      lat_cfg[0] = 3;
      @(negedge clk);
      skip_mask = 4'b1110; tlim = 16'd0; cont = 1'b1; start = 1'b1;
      for (int r = 0; r <= 20; r++) begin
         @(negedge clk);
         if (r == 0) start = 1'b0;
         chk($sformatf("cont strobe r%0d", r), 32'(stage_start),
             (r % 5 == 0 && r <= 10) ? 32'h1 : 32'h0);
         chk($sformatf("cont done r%0d", r), 32'(done), (r % 5 == 4 && r <= 14) ? 1 : 0);
         chk($sformatf("cont busy r%0d", r), 32'(busy), (r < 15) ? 1 : 0);
         if (r == 11) cont = 1'b0;
      end
      repeat (6) @(negedge clk);

      // ---- continuous mode with every stage skipped ----
      @(negedge clk);
      skip_mask = 4'b1111; cont = 1'b1; start = 1'b1;
      for (int r = 0; r <= 6; r++) begin
         @(negedge clk);
         if (r == 0) start = 1'b0;
         chk($sformatf("cont-skip done r%0d", r), 32'(done), (r <= 3) ? 1 : 0);
         chk($sformatf("cont-skip busy r%0d", r), 32'(busy), (r <= 3) ? 1 : 0);
         chk($sformatf("cont-skip strobe r%0d", r), 32'(stage_start), 0);
         if (r == 3) cont = 1'b0;
      end
      repeat (4) @(negedge clk);

      // ---- reset asserted mid-run clears outputs at once ----
      lat_cfg[0] = 3; lat_cfg[1] = 3; lat_cfg[2] = 3; lat_cfg[3] = 3;
      @(negedge clk);
      skip_mask = 4'b0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("pre-rst strobe", 32'(stage_start), 32'h1);
      rst = 1'b1;
      #1;
      chk("async rst strobe", 32'(stage_start), 0);
      chk("async rst busy", 32'(busy), 0);
      chk("async rst state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("post-rst busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
